i2s_dac_tx: RTL

- Downstream stage of the harmonic synthesis top level.
- Takes the 24-bit summed sample `sound_dac_o` through a valid/ready handshake and buffers one sample.
- Serialises each sample MSB-first onto a Philips I2S link (BCLK, LRCLK, SDATA) for the external audio DAC. The mono sample is duplicated on the left and right channels.
- Issues a one-cycle frame-rate request strobe, which drives the synthesiser's `send_i`.

---
 rtl/i2s_dac_tx.sv | 110 +++++++++++
 1 files changed

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter: buffers one mono sample over valid/ready and sends it
// MSB-first in both channel slots, requesting a new sample at every frame start.
module i2s_dac_tx #(
   parameter int WIDTH    = 24,
   parameter int BCLK_DIV = 4,
   parameter int SLOT     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sample_i,
   input  logic             sample_valid_i,
   output logic             sample_ready_o,
   output logic             sample_req_o,
   output logic             underrun_o,
   output logic             bclk_o,
   output logic             lrclk_o,
   output logic             sdata_o
);
   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BW = $clog2(2 * SLOT);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
   localparam logic [BW-1:0] LR_HI    = BW'(2 * SLOT - 2);
   localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);
   localparam logic [BW-1:0] SLOT_M1  = BW'(SLOT - 1);
   localparam logic [BW-1:0] WIDTH_B  = BW'(WIDTH);

   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             bclk_q, bclk_d;
   logic             lrclk_q, lrclk_d;
   logic             sdata_q, sdata_d;
   logic             req_q, req_d;
   logic             underrun_q, underrun_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;

   logic             div_wrap;
   logic             fall;
   logic             frame_start;
   logic             accept;
   logic [BW-1:0]    b_next;
   logic [BW-1:0]    c;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      div_wrap    = (div_cnt_q == DIV_LAST);
      div_cnt_d   = div_wrap ? '0 : div_cnt_q + DW'(1);
      bclk_d      = div_wrap ? ~bclk_q : bclk_q;
      fall        = div_wrap & bclk_q;
      b_next      = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
      bit_cnt_d   = fall ? b_next : bit_cnt_q;
      frame_start = fall & (b_next == '0);
      accept      = sample_valid_i & ~hold_full_q;

      // A sample accepted on the frame-start cycle of an empty buffer waits for the next frame.
      shadow_d    = (frame_start & hold_full_q) ? hold_q : shadow_q;
      hold_d      = accept ? sample_i : hold_q;
      hold_full_d = hold_full_q;
      if (frame_start) hold_full_d = 1'b0;
      if (accept)      hold_full_d = 1'b1;

      req_d      = frame_start;
      underrun_d = frame_start & ~hold_full_q;

      c       = (b_next >= SLOT_B) ? b_next - SLOT_B : b_next;
      shifted = shadow_d << c;
      sdata_d = sdata_q;
      lrclk_d = lrclk_q;
      if (fall) begin
         sdata_d = (c < WIDTH_B) ? shifted[WIDTH-1] : 1'b0;
         lrclk_d = (b_next >= SLOT_M1) && (b_next <= LR_HI);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q   <= '0;
         bit_cnt_q   <= BIT_LAST;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         sdata_q     <= 1'b0;
         req_q       <= 1'b0;
         underrun_q  <= 1'b0;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         shadow_q    <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         bclk_q      <= bclk_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         req_q       <= req_d;
         underrun_q  <= underrun_d;
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         shadow_q    <= shadow_d;
      end
   end

   assign sample_ready_o = ~hold_full_q;
   assign sample_req_o   = req_q;
   assign underrun_o     = underrun_q;
   assign bclk_o         = bclk_q;
   assign lrclk_o        = lrclk_q;
   assign sdata_o        = sdata_q;

endmodule
